// File: rtl/cla_wide_add_seq_if.sv
// Operand/result bus of the wide add/subtract sequencer.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface cla_wide_add_seq_if #(
  parameter int WORDS = 4
) ();
  localparam int W = 16 * WORDS;

  logic         start_valid;
  logic         start_ready;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output start_valid, op_sub, a, b, cin, result_ready,
    input  start_ready, result_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  start_valid, op_sub, a, b, cin, result_ready,
    output start_ready, result_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cla_wide_add_seq.sv
// WORDS*16-bit add/subtract built by stepping one 16-bit carry-lookahead adder
// across the operands, least significant slice first.
module carry_look_ahead_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  // Returns carries c0..c4 of a 4-wide lookahead block.
  function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [4:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  logic [15:0] p, g;
  logic [3:0]  gp, gg;
  logic [4:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic [4:0] t;
    t = '0;
    for (int k = 0; k < 4; k++) begin
      t     = cla4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      gg[k] = t[4];
      gp[k] = &p[4*k +: 4];
    end
  end

  assign gc = cla4(gg, gp, cin);

  always_comb begin
    logic [4:0] t;
    t   = '0;
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      t = cla4(g[4*k +: 4], p[4*k +: 4], gc[k]);
      sum[4*k +: 4] = p[4*k +: 4] ^ t[3:0];
    end
  end

  assign cout = gc[4];
endmodule

module cla_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_wide_add_seq_if.slave    bus,
  output logic [1:0]           dbg_state
);
  localparam int W    = 16 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [W-1:0]    a_r, b_r, sum_r;
  logic            cout_r, ovf_r;
  logic [15:0]     add_a, add_b, add_sum;
  logic            add_cout;
  logic            last;

  assign add_a = a_r[16*idx +: 16];
  assign add_b = b_r[16*idx +: 16];
  assign last  = (idx == IDXW'(WORDS - 1));

  carry_look_ahead_16bit u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start_valid)  state_nx = RUN;
      RUN:     if (last)             state_nx = DONE;
      DONE:    if (bus.result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, so b is inverted at capture and the +1 rides in on carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.op_sub ? ~bus.b : bus.b;
            carry <= bus.op_sub ? 1'b1 : bus.cin;
            sum_r <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_r[16*idx +: 16] <= add_sum;
          carry               <= add_cout;
          if (last) begin
            cout_r <= add_cout;
            ovf_r  <= (a_r[W-1] == b_r[W-1]) & (add_sum[15] != a_r[W-1]);
            idx    <= '0;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready  = (state == IDLE);
  assign bus.result_valid = (state == DONE);
  assign bus.busy         = (state != IDLE);
  assign bus.sum          = sum_r;
  assign bus.cout         = cout_r;
  assign bus.ovf          = ovf_r;
  assign dbg_state        = state;
endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Bench for cla_wide_add_seq: directed corner cases plus random add/sub traffic,
// scored against a plain-arithmetic reference model.
module tb_cla_wide_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  cla_wide_add_seq_if #(.WORDS(WORDS)) bus ();

  cla_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W+1:0] exp_q[$];   // {cout, ovf, sum}

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: wide two's-complement arithmetic straight from the operand values.
  function automatic logic [W+1:0] model(input logic sub, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         co, ov;
    if (sub) begin
      s  = x - y;
      co = (x >= y);
      ov = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      s    = full[W-1:0];
      co   = full[W];
      ov   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    end
    return {co, ov, s};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      default: ;
    endcase
    return v;
  endfunction

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.result_valid && bus.result_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got sum %0h, required no result", bus.sum);
        end else begin
          logic [W+1:0] e;
          e = exp_q.pop_front();
          check("sum",  bus.sum,  e[W-1:0]);
          check("cout", bus.cout, e[W+1]);
          check("ovf",  bus.ovf,  e[W]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: issue one operation, then measure edges from accept to result_valid
  task automatic send(input logic sub, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci);
    int n;
    step();
    bus.start_valid = 1'b1;
    bus.op_sub      = sub;
    bus.a           = x;
    bus.b           = y;
    bus.cin         = ci;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bus.start_ready) break;
      n++;
    end
    if (n >= 200) begin
      check("start_accept_timeout", 128'(n), 128'(0));
      bus.start_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(sub, x, y, ci));
    step();
    bus.start_valid = 1'b0;
    bus.op_sub      = 1'($urandom_range(0, 1));
    bus.a           = rand_word();
    bus.b           = rand_word();
    bus.cin         = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.result_valid && n < 100);
    check("latency", 128'(n), 128'(WORDS));
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         held_cout;
    int           n;

    bus.start_valid  = 1'b0;
    bus.op_sub       = 1'b0;
    bus.a            = '0;
    bus.b            = '0;
    bus.cin          = 1'b0;
    bus.result_ready = 1'b1;

    // reset held three cycles
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sum",          bus.sum,          '0);
    check("rst_cout",         bus.cout,         1'b0);
    check("rst_ovf",          bus.ovf,          1'b0);
    check("rst_result_valid", bus.result_valid, 1'b0);
    check("rst_busy",         bus.busy,         1'b0);
    check("rst_start_ready",  bus.start_ready,  1'b1);

    // directed arithmetic corners
    send(1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    send(1'b0, 64'd999, 64'd0, 1'b1);
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    send(1'b1, 64'd5, 64'd6, 1'b1);
    send(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    send(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);

    // backpressure: result held while a new start is offered
    step();
    bus.result_ready = 1'b0;
    send(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    held_sum  = bus.sum;
    held_cout = bus.cout;
    step();
    bus.start_valid = 1'b1;
    bus.op_sub      = 1'b0;
    bus.a           = 64'd111;
    bus.b           = 64'd222;
    bus.cin         = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_start_ready", bus.start_ready,  1'b0);
      check("bp_valid",       bus.result_valid, 1'b1);
      check("bp_sum_stable",  bus.sum,          held_sum);
      check("bp_cout_stable", bus.cout,         held_cout);
    end
    step();
    bus.result_ready = 1'b1;
    send(1'b0, 64'd111, 64'd222, 1'b0);

    // reset while a result waits in DONE
    step();
    bus.result_ready = 1'b0;
    send(1'b1, 64'd100, 64'd300, 1'b0);
    step();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_done_valid", bus.result_valid, 1'b0);
    check("rst_done_busy",  bus.busy,         1'b0);
    exp_q.delete();
    step();
    rst = 1'b0;
    bus.result_ready = 1'b1;

    // reset in the middle of RUN, then a fresh add
    step();
    bus.start_valid = 1'b1;
    bus.op_sub      = 1'b0;
    bus.a           = 64'hDEAD_BEEF_0000_0001;
    bus.b           = 64'h0000_0000_FFFF_FFFF;
    bus.cin         = 1'b0;
    @(negedge clk);
    check("mid_start_ready", bus.start_ready, 1'b1);
    step();
    bus.start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_busy_before", bus.busy,         1'b1);
    check("mid_valid_before", bus.result_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("mid_busy",        bus.busy,         1'b0);
    check("mid_valid",       bus.result_valid, 1'b0);
    check("mid_sum",         bus.sum,          '0);
    check("mid_cout",        bus.cout,         1'b0);
    check("mid_ovf",         bus.ovf,          1'b0);
    check("mid_start_ready", bus.start_ready,  1'b1);
    step();
    rst = 1'b0;
    send(1'b0, 64'd14, 64'd1, 1'b1);

    // random traffic with occasional result backpressure
    for (int i = 0; i < 40; i++) begin
      logic rr;
      rr = 1'($urandom_range(0, 1));
      step();
      bus.result_ready = rr;
      send(1'($urandom_range(0, 1)), rand_word(), rand_word(), 1'($urandom_range(0, 1)));
      if (!rr) begin
        repeat ($urandom_range(1, 4)) step();
        bus.result_ready = 1'b1;
      end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain", 128'(exp_q.size()), 128'(0));
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_wide_add_seq.md
Name: cla_wide_add_seq

Overview:
Multi-cycle sequencer that performs WORDS*16-bit add/subtract by time-multiplexing one 16-bit carry-lookahead adder instance (carry_look_ahead_16bit, ports a, b, cin, sum, cout).
- Processes one 16-bit slice per cycle, LSW first, and registers the carry between slices.
- Valid/ready handshake on the operand side and on the result side.
- Sits between the wide-arithmetic users and the shared CLA datapath.

Parameters:
WORDS, 4, number of 16-bit slices; operand/result width W = 16*WORDS; legal range 1..16.
IDXW, $clog2(WORDS) (min 1), slice-index counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start_valid  input  1  operand request valid
start_ready  output  1  block can accept operands (high only in IDLE)
op_sub  input  1  0: a+b+cin; 1: a-b (cin ignored)
a  input  W  operand A, captured on start handshake
b  input  W  operand B, captured on start handshake
cin  input  1  carry-in for add
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
sum  output  W  result
cout  output  1  carry out of MSB slice (for sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
Reset:
- rst is synchronous and active-high, sampled on the rising edge of clk; there is one clock.
- On rst: state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, result_valid=0, busy=0.
- start_ready=1 from the first cycle after reset deasserts.
- rst overrides every other input, including mid-RUN and in DONE. The in-flight operation is discarded and no result_valid is produced for it.
States:
- IDLE: start_ready=1. A handshake (start_valid & start_ready) at an edge:
  - captures a_r=a and b_r = op_sub ? ~b : b;
  - sets carry = op_sub ? 1 : cin, clears sum, sets idx=0, goes to RUN.
- RUN: the adder inputs are a_r[16*idx+:16], b_r[16*idx+:16] and carry. Each edge:
  - writes adder sum into sum[16*idx+:16];
  - sets carry = adder cout and increments idx.
  - On the edge where idx==WORDS-1: sets cout = adder cout, sets ovf = (a_r[W-1]==b_r[W-1]) & (adder sum[15] != a_r[W-1]), goes to DONE.
- DONE: result_valid=1. sum/cout/ovf are held stable until result_ready=1 at an edge, then the block returns to IDLE with result_valid=0.
Timing and ordering:
- Latency: result_valid rises exactly WORDS edges after the accepting edge.
- Throughput: one operation per WORDS+2 cycles minimum. result_valid is deasserted in the IDLE cycle between operations.
- start_valid while not in IDLE is ignored (start_ready=0). Operands are never sampled outside the handshake.
- The a/b/cin/op_sub inputs may change freely after the handshake. The result depends only on the captured values.
- Simultaneous result_ready and start_valid in DONE: the result is consumed, the start is not accepted, and it can be accepted on the next (IDLE) edge.
Width rules:
- Sum wraps modulo 2^W.
- cout is the true carry out of bit W-1.
- No internal state other than a_r, b_r, carry, idx, state and the outputs.
- The adder is used combinationally, with no extra pipeline stages.

Test Plan:
1. Reset: assert rst 3 cycles, then deassert -> sum=0, cout=0, ovf=0, result_valid=0, busy=0, start_ready=1. Repeat with rst pulsed while in DONE -> result_valid drops the next cycle.
2. WORDS=4, add a=0x0000_0000_0000_FFFF, b=1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0, ovf=0, result_valid exactly 4 edges after accept. Also a=999, b=0, cin=1 -> sum=1000.
3. Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0.
4. Subtract: a=5, b=6, op_sub=1, cin=1 (ignored) -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0. Then a=0x8000_0000_0000_0000, b=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
5. Backpressure: hold result_ready=0 for 10 cycles while start_valid=1 with new operands -> sum/cout stable, start_ready=0, nothing captured. Raise result_ready -> IDLE, the new operands are accepted next edge, and the correct new result follows.
6. Reset mid-operation: assert rst at idx=2 of RUN -> next cycle IDLE, all outputs 0, no result_valid. A following add 14+1+cin=1 returns sum=16, cout=0.
